// File: rtl/tdt_dm_rst_pkg.sv
// Shared encodings and defaults for the debug-module reset generator.
package tdt_dm_rst_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ASSERT    = 3'd1,
    ST_HOLD      = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_WAIT_DONE = 3'd4
  } rst_state_e;

  typedef enum logic {
    RST_SYS  = 1'b0,
    RST_HART = 1'b1
  } rst_type_e;

  localparam int unsigned DEF_MIN_ASSERT_CYC = 16;
  localparam int unsigned DEF_DONE_TIMEOUT   = 1024;
  localparam int unsigned DEF_CNT_W          = 10;

  // Reset outputs are low only while the sequence is asserting or holding.
  function automatic logic rst_active(input rst_state_e st);
    return (st == ST_ASSERT) || (st == ST_HOLD);
  endfunction

endpackage

// File: rtl/tdt_dm_rst_gen.sv
// Debug-side reset generator: stretches ndmreset/hartreset requests into
// registered active-low resets and reports sticky havereset/timeout status.
module tdt_dm_rst_gen
  import tdt_dm_rst_pkg::*;
#(
  parameter int unsigned MIN_ASSERT_CYC = DEF_MIN_ASSERT_CYC,
  parameter int unsigned DONE_TIMEOUT   = DEF_DONE_TIMEOUT,
  parameter int unsigned CNT_W          = DEF_CNT_W
) (
  input  logic sys_apb_clk,
  input  logic sys_apb_rst,
  input  logic pad_yy_scan_mode,
  input  logic pad_yy_scan_rst_b,
  input  logic dm_ndmreset_req,
  input  logic dm_hartreset_req,
  input  logic dm_ackhavereset,
  input  logic sys_rst_done,
  output logic dm_sys_rst_b,
  output logic dm_hart_rst_b,
  output logic dm_havereset,
  output logic dm_rst_timeout,
  output logic dm_rst_busy
);

  localparam logic [CNT_W-1:0] ASSERT_LAST  = CNT_W'(MIN_ASSERT_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(DONE_TIMEOUT - 1);

  rst_state_e       state_q, state_d;
  rst_type_e        type_q, type_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sys_rst_b_q, hart_rst_b_q;
  logic             havereset_q, timeout_q, busy_q;
  logic             set_havereset, set_timeout;
  logic             req_latched, upgrade;

  assign req_latched = (type_q == RST_SYS) ? dm_ndmreset_req : dm_hartreset_req;
  assign upgrade     = (type_q == RST_HART) && dm_ndmreset_req;

  always_comb begin
    state_d       = state_q;
    type_d        = type_q;
    cnt_d         = cnt_q;
    set_havereset = 1'b0;
    set_timeout   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (dm_ndmreset_req) begin
          type_d  = RST_SYS;
          state_d = ST_ASSERT;
          cnt_d   = '0;
        end else if (dm_hartreset_req) begin
          type_d  = RST_HART;
          state_d = ST_ASSERT;
          cnt_d   = '0;
        end
      end
      ST_ASSERT: begin
        cnt_d = cnt_q + 1'b1;
        if (upgrade) begin
          type_d = RST_SYS;
          cnt_d  = '0;
        end else if (cnt_q == ASSERT_LAST) begin
          state_d = req_latched ? ST_HOLD : ST_RELEASE;
        end
      end
      ST_HOLD: begin
        if (upgrade) begin
          type_d  = RST_SYS;
          cnt_d   = '0;
          state_d = ST_ASSERT;
        end else if (!req_latched) begin
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        cnt_d = '0;
        if (type_q == RST_HART) begin
          set_havereset = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        cnt_d = cnt_q + 1'b1;
        if (sys_rst_done) begin
          set_havereset = 1'b1;
          state_d       = ST_IDLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          set_havereset = 1'b1;
          set_timeout   = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset outputs and busy are decoded from the next state so they switch
  // on the same edge the state register does.
  always_ff @(posedge sys_apb_clk) begin
    if (sys_apb_rst) begin
      state_q      <= ST_IDLE;
      type_q       <= RST_HART;
      cnt_q        <= '0;
      sys_rst_b_q  <= 1'b1;
      hart_rst_b_q <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      type_q       <= type_d;
      cnt_q        <= cnt_d;
      sys_rst_b_q  <= !(rst_active(state_d) && (type_d == RST_SYS));
      hart_rst_b_q <= !rst_active(state_d);
      busy_q       <= (state_d != ST_IDLE);
    end
  end

  always_ff @(posedge sys_apb_clk) begin
    if (sys_apb_rst) begin
      havereset_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      if (set_havereset)        havereset_q <= 1'b1;
      else if (dm_ackhavereset) havereset_q <= 1'b0;
      if (set_timeout)          timeout_q   <= 1'b1;
      else if (dm_ackhavereset) timeout_q   <= 1'b0;
    end
  end

  assign dm_sys_rst_b   = pad_yy_scan_mode ? pad_yy_scan_rst_b : sys_rst_b_q;
  assign dm_hart_rst_b  = pad_yy_scan_mode ? pad_yy_scan_rst_b : hart_rst_b_q;
  assign dm_havereset   = havereset_q;
  assign dm_rst_timeout = timeout_q;
  assign dm_rst_busy    = busy_q;

endmodule

// File: tb/tb_tdt_dm_rst_gen.sv
// Scenario bench for tdt_dm_rst_gen: randomized request lengths checked
// against durations derived from the reset-sequencing rules.
module tb_tdt_dm_rst_gen;

  localparam int MIN = 16;
  localparam int TO  = 1024;

  logic clk = 1'b0;
  logic rst, scan_mode, scan_rst_b, ndm, hart, ack, done;
  logic dm_sys_rst_b, dm_hart_rst_b, dm_havereset, dm_rst_timeout, dm_rst_busy;

  int n_vec = 0;
  int n_err = 0;

  tdt_dm_rst_gen #(
    .MIN_ASSERT_CYC(MIN),
    .DONE_TIMEOUT  (TO),
    .CNT_W         (10)
  ) dut (
    .sys_apb_clk      (clk),
    .sys_apb_rst      (rst),
    .pad_yy_scan_mode (scan_mode),
    .pad_yy_scan_rst_b(scan_rst_b),
    .dm_ndmreset_req  (ndm),
    .dm_hartreset_req (hart),
    .dm_ackhavereset  (ack),
    .sys_rst_done     (done),
    .dm_sys_rst_b     (dm_sys_rst_b),
    .dm_hart_rst_b    (dm_hart_rst_b),
    .dm_havereset     (dm_havereset),
    .dm_rst_timeout   (dm_rst_timeout),
    .dm_rst_busy      (dm_rst_busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int low_len(input int l);
    return (l > MIN) ? l : MIN;
  endfunction

  // Raise a request for l sampled edges, then observe until the hart reset
  // returns high. Leaves the bench just after the release edge.
  task automatic run_req(input bit is_sys, input int l, output int hart_low,
                         output int sys_low, output int first_low, output bit timed_out);
    hart_low = 0; sys_low = 0; first_low = -1; timed_out = 1'b1;
    if (is_sys) ndm = 1'b1; else hart = 1'b1;
    for (int i = 0; i < 400; i++) begin
      step();
      if (i >= l - 1) begin ndm = 1'b0; hart = 1'b0; end
      if (dm_hart_rst_b == 1'b0) begin
        if (first_low < 0) first_low = i;
        hart_low++;
      end
      if (dm_sys_rst_b == 1'b0) sys_low++;
      if (hart_low > 0 && dm_hart_rst_b == 1'b1) begin timed_out = 1'b0; break; end
    end
  endtask

  task automatic pulse_ack();
    ack = 1'b1; step(); ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; step(); step();
    n_vec++; if (dm_sys_rst_b !== 1'b1) begin n_err++; $display("FAIL reset_sys_rst_b: got %b exp 1", dm_sys_rst_b); end
    n_vec++; if (dm_hart_rst_b !== 1'b1) begin n_err++; $display("FAIL reset_hart_rst_b: got %b exp 1", dm_hart_rst_b); end
    n_vec++; if (dm_havereset !== 1'b0) begin n_err++; $display("FAIL reset_havereset: got %b exp 0", dm_havereset); end
    n_vec++; if (dm_rst_timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout: got %b exp 0", dm_rst_timeout); end
    n_vec++; if (dm_rst_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b exp 0", dm_rst_busy); end
    rst = 1'b0; step();
  endtask

  task automatic test_sys_pulse();
    int l, d, hl, sl, fl;
    bit to;
    for (int it = 0; it < 4; it++) begin
      l = (it == 0) ? 1 : int'($urandom_range(1, MIN + 8));
      d = (it == 0) ? 5 : int'($urandom_range(1, 12));
      run_req(1'b1, l, hl, sl, fl, to);
      n_vec++; if (to !== 1'b0) begin n_err++; $display("FAIL sys_release_bound: got timed_out=%b exp 0 (l=%0d)", to, l); end
      n_vec++; if (fl !== 0) begin n_err++; $display("FAIL sys_first_low: got %0d exp 0", fl); end
      n_vec++; if (hl !== low_len(l)) begin n_err++; $display("FAIL sys_hart_low_len: got %0d exp %0d (l=%0d)", hl, low_len(l), l); end
      n_vec++; if (sl !== low_len(l)) begin n_err++; $display("FAIL sys_sys_low_len: got %0d exp %0d (l=%0d)", sl, low_len(l), l); end
      repeat (d) step();
      n_vec++; if (dm_havereset !== 1'b0) begin n_err++; $display("FAIL sys_wait_havereset: got %b exp 0", dm_havereset); end
      n_vec++; if (dm_rst_busy !== 1'b1) begin n_err++; $display("FAIL sys_wait_busy: got %b exp 1", dm_rst_busy); end
      done = 1'b1; step(); done = 1'b0;
      n_vec++; if (dm_havereset !== 1'b1) begin n_err++; $display("FAIL sys_done_havereset: got %b exp 1", dm_havereset); end
      n_vec++; if (dm_rst_timeout !== 1'b0) begin n_err++; $display("FAIL sys_done_timeout: got %b exp 0", dm_rst_timeout); end
      n_vec++; if (dm_rst_busy !== 1'b0) begin n_err++; $display("FAIL sys_done_busy: got %b exp 0", dm_rst_busy); end
      pulse_ack();
      n_vec++; if (dm_havereset !== 1'b0) begin n_err++; $display("FAIL sys_ack_havereset: got %b exp 0", dm_havereset); end
      step();
    end
  endtask

  // Release cycle plus DONE_TIMEOUT waiting cycles before the timeout lands.
  task automatic test_timeout();
    int l, hl, sl, fl, n;
    bit to;
    l = 40;
    run_req(1'b1, l, hl, sl, fl, to);
    n_vec++; if (sl !== l) begin n_err++; $display("FAIL hold_sys_low_len: got %0d exp %0d", sl, l); end
    n_vec++; if (hl !== l) begin n_err++; $display("FAIL hold_hart_low_len: got %0d exp %0d", hl, l); end
    n = 0;
    while (dm_rst_timeout !== 1'b1 && n < TO + 100) begin step(); n++; end
    n_vec++; if (n !== TO + 1) begin n_err++; $display("FAIL timeout_latency: got %0d exp %0d", n, TO + 1); end
    n_vec++; if (dm_havereset !== 1'b1) begin n_err++; $display("FAIL timeout_havereset: got %b exp 1", dm_havereset); end
    n_vec++; if (dm_rst_busy !== 1'b0) begin n_err++; $display("FAIL timeout_busy: got %b exp 0", dm_rst_busy); end
    pulse_ack();
    n_vec++; if (dm_rst_timeout !== 1'b0) begin n_err++; $display("FAIL timeout_ack: got %b exp 0", dm_rst_timeout); end
    step();
  endtask

  task automatic test_hart_only();
    int l, hl, sl, fl;
    bit to;
    for (int it = 0; it < 3; it++) begin
      l = (it == 0) ? 3 : int'($urandom_range(1, MIN + 4));
      run_req(1'b0, l, hl, sl, fl, to);
      n_vec++; if (hl !== low_len(l)) begin n_err++; $display("FAIL hart_low_len: got %0d exp %0d (l=%0d)", hl, low_len(l), l); end
      n_vec++; if (sl !== 0) begin n_err++; $display("FAIL hart_sys_untouched: got %0d low cycles exp 0", sl); end
      n_vec++; if (dm_havereset !== 1'b0) begin n_err++; $display("FAIL hart_release_havereset: got %b exp 0", dm_havereset); end
      step();
      n_vec++; if (dm_havereset !== 1'b1) begin n_err++; $display("FAIL hart_havereset: got %b exp 1", dm_havereset); end
      n_vec++; if (dm_rst_busy !== 1'b0) begin n_err++; $display("FAIL hart_busy: got %b exp 0", dm_rst_busy); end
      pulse_ack();
      step();
    end
  endtask

  task automatic test_upgrade();
    int k, hl, sl, pre_sl;
    for (int it = 0; it < 2; it++) begin
      k = (it == 0) ? 8 : int'($urandom_range(1, MIN - 2));
      done = 1'b1;
      hl = 0; sl = 0; pre_sl = 0;
      hart = 1'b1; step(); hart = 1'b0;
      if (dm_hart_rst_b == 1'b0) hl++;
      for (int i = 0; i < k; i++) begin
        step();
        if (dm_hart_rst_b == 1'b0) hl++;
        if (dm_sys_rst_b == 1'b0) pre_sl++;
      end
      ndm = 1'b1; step(); ndm = 1'b0;
      n_vec++; if (dm_sys_rst_b !== 1'b0) begin n_err++; $display("FAIL upg_sys_low_next: got %b exp 0", dm_sys_rst_b); end
      for (int i = 0; i < 100 && dm_hart_rst_b == 1'b0; i++) begin
        hl++;
        if (dm_sys_rst_b == 1'b0) sl++;
        step();
      end
      n_vec++; if (pre_sl !== 0) begin n_err++; $display("FAIL upg_sys_pre: got %0d exp 0", pre_sl); end
      n_vec++; if (sl !== MIN) begin n_err++; $display("FAIL upg_sys_low_len: got %0d exp %0d (k=%0d)", sl, MIN, k); end
      n_vec++; if (hl !== k + 1 + MIN) begin n_err++; $display("FAIL upg_hart_low_len: got %0d exp %0d", hl, k + 1 + MIN); end
      step();
      n_vec++; if (dm_havereset !== 1'b0) begin n_err++; $display("FAIL upg_release_havereset: got %b exp 0", dm_havereset); end
      step();
      n_vec++; if (dm_havereset !== 1'b1) begin n_err++; $display("FAIL upg_havereset: got %b exp 1", dm_havereset); end
      done = 1'b0;
      pulse_ack();
      step();
    end
  endtask

  task automatic test_ack_collision();
    int hl, sl, fl;
    bit to;
    run_req(1'b0, 1, hl, sl, fl, to);
    ack = 1'b1; step(); ack = 1'b0;
    n_vec++; if (dm_havereset !== 1'b1) begin n_err++; $display("FAIL ack_collision: got %b exp 1", dm_havereset); end
    pulse_ack();
    n_vec++; if (dm_havereset !== 1'b0) begin n_err++; $display("FAIL ack_after_collision: got %b exp 0", dm_havereset); end
    step();
  endtask

  task automatic test_mid_reset();
    ndm = 1'b1; step(); ndm = 1'b0;
    repeat (5) step();
    rst = 1'b1; step();
    n_vec++; if (dm_sys_rst_b !== 1'b1) begin n_err++; $display("FAIL midrst_sys: got %b exp 1", dm_sys_rst_b); end
    n_vec++; if (dm_hart_rst_b !== 1'b1) begin n_err++; $display("FAIL midrst_hart: got %b exp 1", dm_hart_rst_b); end
    n_vec++; if (dm_rst_busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b exp 0", dm_rst_busy); end
    n_vec++; if (dm_havereset !== 1'b0 || dm_rst_timeout !== 1'b0) begin n_err++; $display("FAIL midrst_status: got %b%b exp 00", dm_havereset, dm_rst_timeout); end
    rst = 1'b0; step();
    n_vec++; if (dm_rst_busy !== 1'b0) begin n_err++; $display("FAIL midrst_idle: got busy %b exp 0", dm_rst_busy); end
  endtask

  task automatic test_back_to_back();
    int hl, sl, fl, n;
    bit to;
    run_req(1'b0, 1, hl, sl, fl, to);
    hart = 1'b1; step();
    n_vec++; if (dm_hart_rst_b !== 1'b1) begin n_err++; $display("FAIL b2b_gap: got %b exp 1", dm_hart_rst_b); end
    step();
    n_vec++; if (dm_hart_rst_b !== 1'b0) begin n_err++; $display("FAIL b2b_restart: got %b exp 0", dm_hart_rst_b); end
    hart = 1'b0;
    n = 0;
    while (dm_rst_busy !== 1'b0 && n < 3 * MIN) begin step(); n++; end
    n_vec++; if (dm_rst_busy !== 1'b0) begin n_err++; $display("FAIL b2b_finish: got busy %b exp 0", dm_rst_busy); end
    pulse_ack();
    step();
  endtask

  task automatic test_scan();
    logic v;
    int n;
    ndm = 1'b1; step(); ndm = 1'b0;
    scan_mode = 1'b1;
    for (int i = 0; i < 24; i++) begin
      v = 1'($urandom_range(0, 1));
      scan_rst_b = v; #1;
      n_vec++; if (dm_sys_rst_b !== v || dm_hart_rst_b !== v) begin n_err++; $display("FAIL scan_follow: got %b%b exp %b%b (i=%0d)", dm_sys_rst_b, dm_hart_rst_b, v, v, i); end
      step();
    end
    scan_mode = 1'b0; scan_rst_b = 1'b1; #1;
    n_vec++; if (dm_sys_rst_b !== 1'b1 || dm_rst_busy !== 1'b1) begin n_err++; $display("FAIL scan_exit: got sys %b busy %b exp 1 1", dm_sys_rst_b, dm_rst_busy); end
    done = 1'b1;
    n = 0;
    while (dm_rst_busy !== 1'b0 && n < 10) begin step(); n++; end
    n_vec++; if (dm_havereset !== 1'b1) begin n_err++; $display("FAIL scan_done_havereset: got %b exp 1", dm_havereset); end
    done = 1'b0;
    pulse_ack();
  endtask

  initial begin
    rst = 1'b1; scan_mode = 1'b0; scan_rst_b = 1'b1;
    ndm = 1'b0; hart = 1'b0; ack = 1'b0; done = 1'b0;
    test_reset();
    test_sys_pulse();
    test_timeout();
    test_hart_only();
    test_upgrade();
    test_ack_collision();
    test_back_to_back();
    test_mid_reset();
    test_scan();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
